// File: rtl/registerset_pkg.sv
// Shared defaults and the legal-target rule for the multi-port register set.
// Pure declarations: no logic, no latency, no flow control.
package registerset_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_SEL_WIDTH     = 3;
    localparam int DEF_NUM_REGISTERS = 8;
    localparam int DEF_NUM_RD_PORTS  = 2;
    localparam int DEF_BYPASS        = 1;
    localparam int DEF_ZERO_REG      = 0;

    // A select addresses real storage if it is in range and is not the hard-wired zero register.
    function automatic logic sel_legal(input int unsigned sel,
                                       input int unsigned num_regs,
                                       input logic        zero_reg);
        return (sel < num_regs) && !(zero_reg && (sel == 0));
    endfunction

endpackage

// File: rtl/registerset_rdport.sv
// One read port: register mux, same-cycle write forwarding and pending-load busy flag.
// Purely combinational (0 cycles); no backpressure, busy is advisory to the consumer.
module registerset_rdport
    import registerset_pkg::*;
#(
    parameter int DataWidth     = DEF_DATA_WIDTH,
    parameter int SEL_WIDTH     = DEF_SEL_WIDTH,
    parameter int NUM_REGISTERS = DEF_NUM_REGISTERS,
    parameter int BYPASS        = DEF_BYPASS,
    parameter int ZERO_REG      = DEF_ZERO_REG
) (
    input  logic                               rd_en,
    input  logic [SEL_WIDTH-1:0]               rd_sel,
    input  logic [NUM_REGISTERS*DataWidth-1:0] regs,
    input  logic [NUM_REGISTERS-1:0]           locks,
    input  logic                               wr_fwd,
    input  logic [SEL_WIDTH-1:0]               wr_sel,
    input  logic [DataWidth-1:0]               reg_in,
    output logic [DataWidth-1:0]               rd_dat,
    output logic                               busy
);

    logic                 bypass_hit;
    logic                 rd_legal;
    logic                 locked;
    logic [DataWidth-1:0] stored;

    always_comb begin
        bypass_hit = (BYPASS != 0) && wr_fwd && (wr_sel == rd_sel);
        rd_legal   = sel_legal(32'(rd_sel), NUM_REGISTERS, ZERO_REG != 0);
        stored     = '0;
        locked     = 1'b0;
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            if (rd_sel == SEL_WIDTH'(i)) begin
                stored = regs[i*DataWidth +: DataWidth];
                locked = locks[i];
            end
        end
        rd_dat = '0;
        busy   = 1'b0;
        if (rd_en && rd_legal) begin
            rd_dat = bypass_hit ? reg_in : stored;
            busy   = locked && !bypass_hit;
        end
    end

endmodule

// File: rtl/registerset_mp.sv
// Multi-port register file with write bypass, pending-load locks and a shadow bank for context save/restore/swap.
// Reads 0 cycles, writes/context ops 1 cycle; never stalls, busy flags a locked operand.
module registerset_mp
    import registerset_pkg::*;
#(
    parameter int DataWidth     = DEF_DATA_WIDTH,
    parameter int SEL_WIDTH     = DEF_SEL_WIDTH,
    parameter int NUM_REGISTERS = DEF_NUM_REGISTERS,
    parameter int NUM_RD_PORTS  = DEF_NUM_RD_PORTS,
    parameter int BYPASS        = DEF_BYPASS,
    parameter int ZERO_REG      = DEF_ZERO_REG
) (
    input  logic                              clk,
    input  logic                              res_n,
    input  logic                              wr_en,
    input  logic [SEL_WIDTH-1:0]              wr_sel,
    input  logic [DataWidth-1:0]              reg_in,
    input  logic [NUM_RD_PORTS-1:0]           rd_en,
    input  logic [NUM_RD_PORTS*SEL_WIDTH-1:0] rd_sel,
    output logic [NUM_RD_PORTS*DataWidth-1:0] reg_out,
    output logic [NUM_RD_PORTS-1:0]           busy,
    input  logic                              lock_en,
    input  logic [SEL_WIDTH-1:0]              lock_sel,
    input  logic                              ctx_save,
    input  logic                              ctx_restore
);

    logic [NUM_REGISTERS*DataWidth-1:0] regs_q;
    logic [NUM_REGISTERS*DataWidth-1:0] shadow_q;
    logic [NUM_REGISTERS-1:0]           lock_q;
    logic [NUM_REGISTERS-1:0]           lock_nxt;
    logic                               wr_ok;
    logic                               lock_ok;
    logic [NUM_RD_PORTS-1:0]            rd_en_gated;

    // A restore owns the working bank for the cycle, so it suppresses writes and new locks.
    assign wr_ok   = wr_en && !ctx_restore && sel_legal(32'(wr_sel), NUM_REGISTERS, ZERO_REG != 0);
    assign lock_ok = lock_en && !ctx_restore && sel_legal(32'(lock_sel), NUM_REGISTERS, ZERO_REG != 0);

    // Held reset forces every port quiet, including forwarded write data.
    assign rd_en_gated = rd_en & {NUM_RD_PORTS{res_n}};

    always_comb begin
        lock_nxt = lock_q;
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            if (wr_ok && (wr_sel == SEL_WIDTH'(i)))
                lock_nxt[i] = 1'b0;
            if (lock_ok && (lock_sel == SEL_WIDTH'(i)))
                lock_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            regs_q   <= '0;
            shadow_q <= '0;
            lock_q   <= '0;
        end else if (ctx_restore) begin
            regs_q <= shadow_q;
            lock_q <= '0;
            if (ctx_save)
                shadow_q <= regs_q;
        end else begin
            if (ctx_save)
                shadow_q <= regs_q;
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                if (wr_ok && (wr_sel == SEL_WIDTH'(i)))
                    regs_q[i*DataWidth +: DataWidth] <= reg_in;
            end
            lock_q <= lock_nxt;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rdport
        registerset_rdport #(
            .DataWidth    (DataWidth),
            .SEL_WIDTH    (SEL_WIDTH),
            .NUM_REGISTERS(NUM_REGISTERS),
            .BYPASS       (BYPASS),
            .ZERO_REG     (ZERO_REG)
        ) u_rdport (
            .rd_en (rd_en_gated[p]),
            .rd_sel(rd_sel[p*SEL_WIDTH +: SEL_WIDTH]),
            .regs  (regs_q),
            .locks (lock_q),
            .wr_fwd(wr_ok),
            .wr_sel(wr_sel),
            .reg_in(reg_in),
            .rd_dat(reg_out[p*DataWidth +: DataWidth]),
            .busy  (busy[p])
        );
    end

endmodule

// File: tb/tb_registerset_mp.sv
// Bench for registerset_mp: two configurations share one stimulus stream and are checked
// against an array-based model of the register, shadow and lock state.
module tb_registerset_mp;

    logic        clk;
    logic        res_n;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [7:0]  reg_in;
    logic [1:0]  rd_en;
    logic [5:0]  rd_sel;
    logic        lock_en;
    logic [2:0]  lock_sel;
    logic        ctx_save;
    logic        ctx_restore;
    logic [15:0] out0, out1;
    logic [1:0]  busy0, busy1;

    int compared = 0;
    int mismatched = 0;

    // cfg 0: 8 regs, bypass, no zero reg.  cfg 1: 6 regs, no bypass, zero reg.
    registerset_mp #(.DataWidth(8), .SEL_WIDTH(3), .NUM_REGISTERS(8), .NUM_RD_PORTS(2),
                     .BYPASS(1), .ZERO_REG(0)) dut0 (
        .clk(clk), .res_n(res_n), .wr_en(wr_en), .wr_sel(wr_sel), .reg_in(reg_in),
        .rd_en(rd_en), .rd_sel(rd_sel), .reg_out(out0), .busy(busy0),
        .lock_en(lock_en), .lock_sel(lock_sel), .ctx_save(ctx_save), .ctx_restore(ctx_restore));

    registerset_mp #(.DataWidth(8), .SEL_WIDTH(3), .NUM_REGISTERS(6), .NUM_RD_PORTS(2),
                     .BYPASS(0), .ZERO_REG(1)) dut1 (
        .clk(clk), .res_n(res_n), .wr_en(wr_en), .wr_sel(wr_sel), .reg_in(reg_in),
        .rd_en(rd_en), .rd_sel(rd_sel), .reg_out(out1), .busy(busy1),
        .lock_en(lock_en), .lock_sel(lock_sel), .ctx_save(ctx_save), .ctx_restore(ctx_restore));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         nr [2] = '{8, 6};
    bit         bp [2] = '{1'b1, 1'b0};
    bit         zr [2] = '{1'b0, 1'b1};
    logic [7:0] m_reg  [2][8];
    logic [7:0] m_sh   [2][8];
    bit         m_lock [2][8];

    function automatic bit legal(int c, int sel);
        return (sel < nr[c]) && !(zr[c] && sel == 0);
    endfunction

    function automatic bit hit(int c, int sel);
        return bp[c] && wr_en && !ctx_restore && legal(c, int'(wr_sel)) && (int'(wr_sel) == sel);
    endfunction

    function automatic logic [7:0] exp_rd(int c, int p);
        int sel = int'(rd_sel[p*3 +: 3]);
        if (!res_n || !rd_en[p] || !legal(c, sel)) return 8'h00;
        if (hit(c, sel)) return reg_in;
        return m_reg[c][sel];
    endfunction

    function automatic logic exp_busy(int c, int p);
        int sel = int'(rd_sel[p*3 +: 3]);
        if (!res_n || !rd_en[p] || !legal(c, sel)) return 1'b0;
        return m_lock[c][sel] && !hit(c, sel);
    endfunction

    function automatic logic [7:0] out(int c, int p);
        return (c == 0) ? out0[p*8 +: 8] : out1[p*8 +: 8];
    endfunction

    function automatic logic bsy(int c, int p);
        return (c == 0) ? busy0[p] : busy1[p];
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 8; i++) begin
                m_reg[c][i] = 8'h00; m_sh[c][i] = 8'h00; m_lock[c][i] = 1'b0;
            end
    endtask

    task automatic model_edge();
        logic [7:0] t;
        for (int c = 0; c < 2; c++) begin
            if (ctx_restore) begin
                for (int i = 0; i < 8; i++) begin
                    t = m_reg[c][i];
                    m_reg[c][i] = m_sh[c][i];
                    if (ctx_save) m_sh[c][i] = t;
                    m_lock[c][i] = 1'b0;
                end
            end else begin
                if (ctx_save)
                    for (int i = 0; i < 8; i++) m_sh[c][i] = m_reg[c][i];
                if (wr_en && legal(c, int'(wr_sel))) begin
                    m_reg[c][wr_sel]  = reg_in;
                    m_lock[c][wr_sel] = 1'b0;
                end
                if (lock_en && legal(c, int'(lock_sel)))
                    m_lock[c][lock_sel] = 1'b1;
            end
        end
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all(string tag);
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("%s_c%0d_p%0d_out", tag, c, p), out(c, p), exp_rd(c, p));
                chk($sformatf("%s_c%0d_p%0d_busy", tag, c, p), {7'd0, bsy(c, p)}, {7'd0, exp_busy(c, p)});
            end
    endtask

    task automatic idle();
        wr_en = 0; wr_sel = 0; reg_in = 0; rd_en = 0; rd_sel = 0;
        lock_en = 0; lock_sel = 0; ctx_save = 0; ctx_restore = 0;
    endtask

    task automatic rd(int p, int sel);
        rd_en[p] = 1'b1;
        rd_sel[p*3 +: 3] = 3'(sel);
    endtask

    task automatic wr(int sel, logic [7:0] d);
        wr_en = 1'b1; wr_sel = 3'(sel); reg_in = d;
    endtask

    // Inputs held from a falling edge are committed at the next rising edge.
    task automatic tick();
        @(posedge clk);
        if (res_n) model_edge();
        @(negedge clk);
    endtask

    initial begin
        idle();
        res_n = 1'b0;
        model_clear();
        rd(0, 3); rd(1, 2);
        #3 check_all("reset");
        chk("reset_out", out(0, 0), 8'h00);
        @(negedge clk);
        res_n = 1'b1;

        // Reset asserted mid-cycle with a write and reads pending
        idle(); wr(3, 8'h33); tick();
        idle(); wr(2, 8'hC3); rd(0, 3); rd(1, 2);
        #2 res_n = 1'b0; model_clear();
        #1 check_all("rst_mid");
        chk("rst_mid_byp", out(0, 1), 8'h00);
        @(posedge clk);
        @(negedge clk);
        res_n = 1'b1;
        idle(); wr(3, 8'h5A); tick();
        idle(); rd(0, 3);
        #1 check_all("r3");
        chk("r3_readback", out(0, 0), 8'h5A);
        chk("r3_readback_c1", out(1, 0), 8'h5A);
        tick();

        // Bypass versus registered write
        idle(); wr(2, 8'hC3); rd(1, 2);
        #1 check_all("byp");
        chk("byp_on", out(0, 1), 8'hC3);
        chk("byp_off_old", out(1, 1), 8'h00);
        tick();
        idle(); rd(1, 2);
        #1 chk("byp_off_next", out(1, 1), 8'hC3);
        tick();

        // Lock, write-release, simultaneous lock+write
        idle(); lock_en = 1; lock_sel = 5; rd(0, 5);
        #1 check_all("lock_edge");
        chk("lock_same_cycle", {7'd0, busy0[0]}, 8'h00);
        tick();
        idle(); rd(0, 5);
        #1 check_all("lock_busy");
        chk("lock_busy_c0", {7'd0, busy0[0]}, 8'h01);
        tick();
        idle(); wr(5, 8'h11); rd(0, 5);
        #1 check_all("lock_wr");
        chk("lock_wr_byp", {7'd0, busy0[0]}, 8'h00);
        chk("lock_wr_nobyp", {7'd0, busy1[0]}, 8'h01);
        tick();
        idle(); rd(0, 5);
        #1 check_all("lock_rel");
        chk("lock_rel_c1", {7'd0, busy1[0]}, 8'h00);
        tick();
        idle(); wr(6, 8'h66); lock_en = 1; lock_sel = 6; tick();
        idle(); rd(0, 6);
        #1 check_all("lockwr");
        chk("lockwr_data", out(0, 0), 8'h66);
        chk("lockwr_busy", {7'd0, busy0[0]}, 8'h01);
        tick();

        // Save, clobber, restore with a dropped write and lock
        for (int i = 0; i < 8; i++) begin idle(); wr(i, 8'(8'h10 + i)); tick(); end
        idle(); ctx_save = 1; tick();
        for (int i = 0; i < 8; i++) begin idle(); wr(i, 8'hFF); tick(); end
        idle(); lock_en = 1; lock_sel = 1; tick();
        idle(); ctx_restore = 1; wr(4, 8'h99); lock_en = 1; lock_sel = 2; rd(0, 4); rd(1, 1);
        #1 check_all("restore_cyc");
        chk("restore_pre", out(0, 0), 8'hFF);
        tick();
        for (int i = 0; i < 8; i++) begin
            idle(); rd(0, i); rd(1, (i + 1) % 8);
            #1 check_all("restored");
            chk($sformatf("restored_r%0d", i), out(0, 0), 8'(8'h10 + i));
            chk($sformatf("restored_busy_r%0d", i), {7'd0, busy0[0]}, 8'h00);
            tick();
        end

        // Swap twice
        for (int i = 0; i < 8; i++) begin idle(); wr(i, 8'h55); tick(); end
        idle(); ctx_save = 1; tick();
        for (int i = 0; i < 8; i++) begin idle(); wr(i, 8'hAA); tick(); end
        idle(); ctx_save = 1; ctx_restore = 1; tick();
        idle(); rd(0, 3); rd(1, 5);
        #1 check_all("swap1");
        chk("swap1_val", out(0, 0), 8'h55);
        tick();
        idle(); ctx_save = 1; ctx_restore = 1; tick();
        idle(); rd(0, 3); rd(1, 5);
        #1 check_all("swap2");
        chk("swap2_val", out(0, 1), 8'hAA);
        tick();

        // Zero register and out-of-range select
        idle(); wr(0, 8'h77); lock_en = 1; lock_sel = 0; tick();
        idle(); rd(0, 0);
        #1 check_all("zero");
        chk("zero_c1_out", out(1, 0), 8'h00);
        chk("zero_c1_busy", {7'd0, busy1[0]}, 8'h00);
        chk("zero_c0_out", out(0, 0), 8'h77);
        tick();
        idle(); wr(7, 8'h3C); tick();
        idle(); rd(0, 7);
        #1 check_all("oor");
        chk("oor_c1", out(1, 0), 8'h00);
        chk("oor_c0", out(0, 0), 8'h3C);
        tick();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            wr_en       = 1'($urandom_range(0, 1));
            wr_sel      = 3'($urandom_range(0, 7));
            reg_in      = 8'($urandom);
            rd_en       = 2'($urandom_range(0, 3));
            rd_sel      = 6'($urandom_range(0, 63));
            lock_en     = 1'($urandom_range(0, 1));
            lock_sel    = 3'($urandom_range(0, 7));
            ctx_save    = ($urandom_range(0, 9) == 0);
            ctx_restore = ($urandom_range(0, 11) == 0);
            #1 check_all("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
